stream_rx_fifo_core: RTL and testbench
======================================

Name: stream_rx_fifo_core

Overview:
- Host-to-device counterpart of the SRAM-backed stream FIFO.
- Accepts 16-bit words from the USB stream port (active-low write strobe) under STREAM_READY flow control, and buffers them in an internal circular buffer.
- Presents the buffered words to downstream logic as a first-word-fall-through (FWFT) FIFO.
- Host arms a transfer of N words through the 8-bit register bus; the block reports done, overflow, unexpected-data and fill-level status.

Parameters:
ABUSWIDTH, 16, bus address width
DEPTH_BITS, 10, log2 of buffer depth in 16-bit words (default 1024)
READY_MARGIN, 4, minimum free words required to keep STREAM_READY high (host may write this many words after READY falls)

Ports:
BUS_CLK  in  1  clock for all logic; stream port is synchronous to it
RST  in  1  synchronous, active-high reset
BUS_ADD  in  ABUSWIDTH  register address
BUS_DATA_IN  in  8  register write data
BUS_DATA_OUT  out  8  register read data, registered
BUS_WR  in  1  register write strobe
BUS_RD  in  1  register read strobe
STREAM_WRITE_N  in  1  low = STREAM_DATA valid this cycle
STREAM_DATA  in  16  incoming word
STREAM_READY  out  1  block can accept words
FIFO_READ_NEXT  in  1  pop head word
FIFO_EMPTY  out  1  buffer empty
FIFO_DATA  out  16  head word, valid while !FIFO_EMPTY

Behaviour:
- Reset: internal reset IRST = RST | (BUS_WR & BUS_ADD==0).
- On IRST: pointers 0, state IDLE, counters 0, flags 0, STREAM_READY=0, FIFO_EMPTY=1, BUS_DATA_OUT unchanged.
- Registers, write side:
  - addr 1..3: RX_COUNT[7:0], [15:8], [23:16], unit words.
  - A write to addr 3 generates START one cycle later.
- Registers, read side (BUS_DATA_OUT updated the cycle after BUS_RD; out-of-range addresses return 0):
  - 0: VERSION=1.
  - 1..3: RX_COUNT.
  - 4: status {4'b0, unexpected, overflow, done, busy}.
  - 5: FILL[7:0]. Reading 5 also captures FILL[15:8] into a shadow.
  - 6: shadow FILL[15:8], zero-extended when DEPTH_BITS<16.
  - 7: REMAIN[7:0].
- Buffer:
  - wr_ptr/rd_ptr are DEPTH_BITS+1 bits wide.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits are equal.
  - FILL = wr_ptr - rd_ptr, modulo 2^(DEPTH_BITS+1), range 0..2^DEPTH_BITS.
  - FIFO_DATA = mem[rd_ptr] (asynchronous read). FIFO_EMPTY = empty.
  - A word accepted at edge k is visible (FIFO_EMPTY=0) after edge k.
- Pop: FIFO_READ_NEXT with empty=1 is ignored; pointer does not move.
- Accept: STREAM_WRITE_N==0 while state==RECV and full==0 (full evaluated before the edge). Writes mem[wr_ptr], increments wr_ptr, decrements REMAIN.
  - Simultaneous pop and write when full: write dropped, pop performed.
  - Simultaneous pop and write otherwise: both performed, FILL unchanged.
- Drops:
  - Write strobe in RECV while full: word dropped, overflow sticky set.
  - Write strobe in IDLE or DONE: word dropped, unexpected sticky set.
  - Both flags clear only on IRST or START.
- FSM:
  - IDLE: busy=0. START → RECV with REMAIN=RX_COUNT; if RX_COUNT==0, go to DONE instead.
  - RECV: busy=1. The accept that brings REMAIN from 1 to 0 → DONE.
  - DONE: done=1, busy=0. START → RECV (re-arm).
  - START in RECV reloads REMAIN (abort plus restart). Buffer contents are kept.
- STREAM_READY:
  - Registered: next = (state==RECV) & (REMAIN_next!=0) & (free_next >= READY_MARGIN), where free = 2^DEPTH_BITS - FILL.
  - One-cycle latency. Forced 0 by IRST in the same cycle.
- Wrap-around: pointers wrap modulo 2^(DEPTH_BITS+1); data continuity holds across the wrap.
- Reset mid-transfer: buffer flushed, state IDLE, host must re-arm.

Test Plan:
- RX_COUNT=5, write addr3, send 0x1111..0x5555 with WRITE_N low → READY=1 two cycles after the addr3 write; after the 5th word state DONE, READY=0, status=0x02; pops return 0x1111..0x5555, then FIFO_EMPTY=1.
- DEPTH_BITS=4, RX_COUNT=100, no pops, continuous strobe → READY falls once FILL≥13; 16 words stored; the 17th strobe sets overflow (status=0x05); FILL reads 16 via addr5/6.
- Strobe in IDLE with data 0xBEEF → FIFO_EMPTY stays 1, status=0x08; START with RX_COUNT=0 → status=0x02, READY never asserts.
- DEPTH_BITS=4, stream 40 words interleaved with pops (one pop every other cycle) → output sequence matches input in order across pointer wrap, no overflow flag set.
- Mid-transfer write to addr 0 after 3 of 10 words → READY=0 next cycle, FIFO_EMPTY=1, status=0x00, REMAIN=0; re-arm with RX_COUNT=2 completes normally.
- Simultaneous pop and write when full (DEPTH_BITS=4) → FILL goes 16→15, overflow set, written word absent from output.

Source files
------------

// File: rtl/stream_rx_fifo_core.sv
`timescale 1ns/1ps
// Host-to-device stream receiver: accepts a host-armed number of 16-bit words
// into a circular buffer and presents them downstream as an FWFT FIFO.
module stream_rx_fifo_core #(
    parameter int ABUSWIDTH    = 16,
    parameter int DEPTH_BITS   = 10,
    parameter int READY_MARGIN = 4
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    input  logic                 STREAM_WRITE_N,
    input  logic [15:0]          STREAM_DATA,
    output logic                 STREAM_READY,
    input  logic                 FIFO_READ_NEXT,
    output logic                 FIFO_EMPTY,
    output logic [15:0]          FIFO_DATA
);

    localparam int PW    = DEPTH_BITS + 1;
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [PW-1:0] CAP    = PW'(DEPTH);
    localparam logic [PW-1:0] MARGIN = PW'(READY_MARGIN);

    localparam logic [ABUSWIDTH-1:0] A_VER    = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] A_CNT0   = ABUSWIDTH'(1);
    localparam logic [ABUSWIDTH-1:0] A_CNT1   = ABUSWIDTH'(2);
    localparam logic [ABUSWIDTH-1:0] A_CNT2   = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] A_STAT   = ABUSWIDTH'(4);
    localparam logic [ABUSWIDTH-1:0] A_FILL0  = ABUSWIDTH'(5);
    localparam logic [ABUSWIDTH-1:0] A_FILL1  = ABUSWIDTH'(6);
    localparam logic [ABUSWIDTH-1:0] A_REMAIN = ABUSWIDTH'(7);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t         state, state_next;
    logic [23:0]    rx_count;
    logic [23:0]    remain, remain_next;
    logic [PW-1:0]  wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [PW-1:0]  fill, fill_next, free_next;
    logic [15:0]    fill16;
    logic [7:0]     fill_shadow;
    logic [7:0]     rd_mux;
    logic           irst, start, full, empty, strobe, accept, pop;
    logic           overflow, unexpected, busy, done, ready_next;

    logic [15:0] mem [0:DEPTH-1];

    // A bus write to address 0 acts as a soft reset of the whole block.
    assign irst   = RST | (BUS_WR & (BUS_ADD == A_VER));
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                    (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
    assign strobe = ~STREAM_WRITE_N;
    assign accept = strobe && (state == RECV) && !full;
    assign pop    = FIFO_READ_NEXT && !empty;
    assign fill   = wr_ptr - rd_ptr;
    assign fill16 = 16'(fill);

    assign FIFO_EMPTY   = empty;
    assign FIFO_DATA    = mem[rd_ptr[DEPTH_BITS-1:0]];

    always_comb begin
        state_next  = state;
        remain_next = remain;
        busy        = (state == RECV);
        done        = (state == DONE);
        if (start) begin
            remain_next = rx_count;
            state_next  = (rx_count == 24'd0) ? DONE : RECV;
        end else if (accept) begin
            remain_next = remain - 24'd1;
            if (remain == 24'd1) state_next = DONE;
        end
    end

    // READY looks one edge ahead so the host sees it with a single cycle of latency.
    always_comb begin
        wr_ptr_next = wr_ptr + {{DEPTH_BITS{1'b0}}, accept};
        rd_ptr_next = rd_ptr + {{DEPTH_BITS{1'b0}}, pop};
        fill_next   = wr_ptr_next - rd_ptr_next;
        free_next   = CAP - fill_next;
        ready_next  = (state_next == RECV) && (remain_next != 24'd0) &&
                      (free_next >= MARGIN);
    end

    always_ff @(posedge BUS_CLK) begin
        if (irst) begin
            state        <= IDLE;
            remain       <= 24'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            unexpected   <= 1'b0;
            STREAM_READY <= 1'b0;
            start        <= 1'b0;
            rx_count     <= 24'd0;
        end else begin
            state        <= state_next;
            remain       <= remain_next;
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            STREAM_READY <= ready_next;
            start        <= BUS_WR && (BUS_ADD == A_CNT2);
            if (start) begin
                overflow   <= 1'b0;
                unexpected <= 1'b0;
            end else if (strobe) begin
                if (state != RECV) unexpected <= 1'b1;
                else if (full)     overflow   <= 1'b1;
            end
            if (BUS_WR) begin
                if (BUS_ADD == A_CNT0) rx_count[7:0]   <= BUS_DATA_IN;
                if (BUS_ADD == A_CNT1) rx_count[15:8]  <= BUS_DATA_IN;
                if (BUS_ADD == A_CNT2) rx_count[23:16] <= BUS_DATA_IN;
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (accept) mem[wr_ptr[DEPTH_BITS-1:0]] <= STREAM_DATA;
    end

    always_comb begin
        rd_mux = 8'd0;
        case (BUS_ADD)
            A_VER:    rd_mux = 8'd1;
            A_CNT0:   rd_mux = rx_count[7:0];
            A_CNT1:   rd_mux = rx_count[15:8];
            A_CNT2:   rd_mux = rx_count[23:16];
            A_STAT:   rd_mux = {4'b0, unexpected, overflow, done, busy};
            A_FILL0:  rd_mux = fill16[7:0];
            A_FILL1:  rd_mux = fill_shadow;
            A_REMAIN: rd_mux = remain[7:0];
            default:  rd_mux = 8'd0;
        endcase
    end

    // Reading the low fill byte freezes the high byte so a two-byte read is coherent.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RD) begin
            BUS_DATA_OUT <= rd_mux;
            if (BUS_ADD == A_FILL0) fill_shadow <= fill16[15:8];
        end
    end

endmodule

// File: tb/tb_stream_rx_fifo_core.sv
`timescale 1ns/1ps
// Bench for stream_rx_fifo_core: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_stream_rx_fifo_core;

    logic        BUS_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] BUS_ADD = '0;
    logic [7:0]  BUS_DATA_IN = '0;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_WR = 1'b0;
    logic        BUS_RD = 1'b0;
    logic        STREAM_WRITE_N = 1'b1;
    logic [15:0] STREAM_DATA = '0;
    logic        STREAM_READY;
    logic        FIFO_READ_NEXT = 1'b0;
    logic        FIFO_EMPTY;
    logic [15:0] FIFO_DATA;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    stream_rx_fifo_core #(.ABUSWIDTH(16), .DEPTH_BITS(4), .READY_MARGIN(4)) dut (
        .BUS_CLK(BUS_CLK), .RST(RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD),
        .STREAM_WRITE_N(STREAM_WRITE_N), .STREAM_DATA(STREAM_DATA),
        .STREAM_READY(STREAM_READY), .FIFO_READ_NEXT(FIFO_READ_NEXT),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: buffer as a queue, 16-word capacity, margin 4.
    bit [15:0]   mq[$];
    int          m_mode = 0;      // 0 idle, 1 receiving, 2 done
    int unsigned m_remain = 0;
    int unsigned m_rxc = 0;
    bit          m_start = 0, m_ovf = 0, m_unx = 0, m_ready = 0;

    always @(posedge BUS_CLK) begin
        bit irst, full, strobe, acc, pop;
        irst = RST || (BUS_WR && BUS_ADD == 16'd0);
        if (irst) begin
            mq.delete();
            m_mode = 0; m_remain = 0; m_rxc = 0;
            m_start = 0; m_ovf = 0; m_unx = 0; m_ready = 0;
        end else begin
            full   = (mq.size() == 16);
            strobe = !STREAM_WRITE_N;
            acc    = strobe && m_mode == 1 && !full;
            pop    = FIFO_READ_NEXT && mq.size() != 0;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(STREAM_DATA);
            if (m_start) begin
                m_ovf = 0; m_unx = 0;
            end else if (strobe) begin
                if (m_mode != 1) m_unx = 1;
                else if (full)   m_ovf = 1;
            end
            if (m_start) begin
                m_remain = m_rxc;
                m_mode   = (m_rxc == 0) ? 2 : 1;
            end else if (acc) begin
                m_remain--;
                if (m_remain == 0) m_mode = 2;
            end
            if (BUS_WR && BUS_ADD == 16'd1) m_rxc[7:0]   = BUS_DATA_IN;
            if (BUS_WR && BUS_ADD == 16'd2) m_rxc[15:8]  = BUS_DATA_IN;
            if (BUS_WR && BUS_ADD == 16'd3) m_rxc[23:16] = BUS_DATA_IN;
            m_start = BUS_WR && BUS_ADD == 16'd3;
            m_ready = (m_mode == 1) && (m_remain != 0) && (16 - mq.size() >= 4);
        end
    end

    always @(negedge BUS_CLK) begin
        if (chk_en) begin
            chk("model_empty", FIFO_EMPTY, (mq.size() == 0));
            chk("model_ready", STREAM_READY, m_ready);
            if (mq.size() != 0) chk("model_head", FIFO_DATA, mq[0]);
        end
    end

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic bus_write(input int addr, input int data);
        BUS_WR = 1'b1; BUS_ADD = 16'(addr); BUS_DATA_IN = 8'(data);
        tick();
        BUS_WR = 1'b0;
    endtask

    task automatic bus_read(input string name, input int addr, input int exp);
        BUS_RD = 1'b1; BUS_ADD = 16'(addr);
        tick();
        BUS_RD = 1'b0;
        chk(name, BUS_DATA_OUT, exp);
    endtask

    task automatic arm(input int count);
        bus_write(1, count & 8'hFF);
        bus_write(2, (count >> 8) & 8'hFF);
        bus_write(3, (count >> 16) & 8'hFF);
    endtask

    task automatic send(input int w);
        STREAM_WRITE_N = 1'b0; STREAM_DATA = 16'(w);
        tick();
        STREAM_WRITE_N = 1'b1;
    endtask

    task automatic pop_chk(input string name, input int exp);
        chk(name, FIFO_DATA, exp);
        FIFO_READ_NEXT = 1'b1;
        tick();
        FIFO_READ_NEXT = 1'b0;
    endtask

    initial begin
        int sent, popped;
        tick(); tick();
        RST = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("rst_empty", FIFO_EMPTY, 1);
        chk("rst_ready", STREAM_READY, 0);
        bus_read("rst_status", 4, 8'h00);
        bus_read("version", 0, 8'h01);
        bus_read("out_of_range", 8, 8'h00);

        // Basic five-word transfer.
        arm(5);
        chk("t1_ready_lat1", STREAM_READY, 0);
        tick();
        chk("t1_ready_lat2", STREAM_READY, 1);
        for (int i = 1; i <= 5; i++) send(16'h1111 * i);
        chk("t1_ready_done", STREAM_READY, 0);
        bus_read("t1_status", 4, 8'h02);
        bus_read("t1_remain", 7, 8'h00);
        for (int i = 1; i <= 5; i++) pop_chk("t1_pop", 16'h1111 * i);
        chk("t1_empty", FIFO_EMPTY, 1);

        // Fill to capacity, then one strobe too many.
        bus_write(0, 0);
        arm(100);
        tick();
        for (int i = 1; i <= 17; i++) begin
            send(16'h2000 + i);
            if (i == 12) chk("t2_ready_12", STREAM_READY, 1);
            if (i == 13) chk("t2_ready_13", STREAM_READY, 0);
        end
        bus_read("t2_status", 4, 8'h05);
        bus_read("t2_fill_lo", 5, 8'h10);
        bus_read("t2_fill_hi", 6, 8'h00);
        bus_read("t2_remain", 7, 8'h54);
        chk("t2_head", FIFO_DATA, 16'h2001);

        // Strobe while idle, then a zero-length arm.
        bus_write(0, 0);
        send(16'hBEEF);
        chk("t3_empty", FIFO_EMPTY, 1);
        bus_read("t3_status_unx", 4, 8'h08);
        arm(0);
        tick();
        bus_read("t3_status_zero", 4, 8'h02);
        tick(); tick();
        chk("t3_ready", STREAM_READY, 0);

        // 40 words through a 16-word buffer with pops every other cycle.
        bus_write(0, 0);
        arm(40);
        tick();
        sent = 0; popped = 0;
        for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
            FIFO_READ_NEXT = cyc[0];
            if (FIFO_READ_NEXT && !FIFO_EMPTY) begin
                chk("t4_order", FIFO_DATA, 16'h4000 + popped);
                popped++;
            end
            if (sent < 40 && STREAM_READY) begin
                STREAM_WRITE_N = 1'b0; STREAM_DATA = 16'(16'h4000 + sent);
                sent++;
            end else begin
                STREAM_WRITE_N = 1'b1;
            end
            tick();
        end
        FIFO_READ_NEXT = 1'b0; STREAM_WRITE_N = 1'b1;
        chk("t4_popped_count", popped, 40);
        bus_read("t4_status", 4, 8'h02);

        // Soft reset mid-transfer, then re-arm.
        bus_write(0, 0);
        arm(10);
        tick();
        for (int i = 0; i < 3; i++) send(16'h3000 + i);
        bus_write(0, 0);
        chk("t5_ready", STREAM_READY, 0);
        chk("t5_empty", FIFO_EMPTY, 1);
        bus_read("t5_status", 4, 8'h00);
        bus_read("t5_remain", 7, 8'h00);
        arm(2);
        tick();
        send(16'h5A01);
        send(16'h5A02);
        bus_read("t5_status_done", 4, 8'h02);
        pop_chk("t5_pop0", 16'h5A01);
        pop_chk("t5_pop1", 16'h5A02);
        chk("t5_empty_end", FIFO_EMPTY, 1);

        // Pop and write together while full: write dropped.
        bus_write(0, 0);
        arm(100);
        tick();
        for (int i = 0; i < 16; i++) send(16'h6000 + i);
        bus_read("t6_status_full", 4, 8'h01);
        bus_read("t6_fill_16", 5, 8'h10);
        STREAM_WRITE_N = 1'b0; STREAM_DATA = 16'hDEAD; FIFO_READ_NEXT = 1'b1;
        tick();
        STREAM_WRITE_N = 1'b1; FIFO_READ_NEXT = 1'b0;
        bus_read("t6_fill_15", 5, 8'h0F);
        bus_read("t6_status_ovf", 4, 8'h05);
        for (int i = 1; i < 16; i++) pop_chk("t6_drain", 16'h6000 + i);
        chk("t6_empty", FIFO_EMPTY, 1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
